// File: rtl/fifo_arb_pkg.sv
// Shared constants and helpers for the FIFO write-port arbiter.
// Optional build macro: FIFO_ARB_TAG_EN (source index prepended to write data).
package fifo_arb_pkg;

    localparam int MAX_REQ = 16;
    localparam int PTR_W   = 4;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit of req in the order ptr, ptr+1, ... wrapping at n.
    function automatic logic [PTR_W-1:0] rr_search(
        input logic [MAX_REQ-1:0] req,
        input logic [PTR_W-1:0]   ptr,
        input int                 n
    );
        logic [PTR_W-1:0] pick;
        int               k;
        pick = ptr;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (i < n) begin
                k = int'(ptr) + i;
                if (k >= n) k = k - n;
                if (req[k]) pick = PTR_W'(k);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr.sv
// Combinational round-robin pick over the occupied holding registers.
// Optional build macro: none here (see FIFO_ARB_TAG_EN in the top).
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_grant
);

    logic [MAX_REQ-1:0] req_ext;
    logic [PTR_W-1:0]   pick;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
        pick                   = rr_search(req_ext, PTR_W'(ptr), NUM_REQ);
        any_grant              = |req;
        grant_idx              = IDX_W'(pick);
        grant_oh               = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_oh[i] = any_grant && (pick == PTR_W'(i));
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin sharing of one FIFO write port between NUM_REQ producers.
// Optional build macro: FIFO_ARB_TAG_EN -> o_Wr_Data = {grant_idx, data}.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 8,
    localparam int IDX_W   = idx_w(NUM_REQ),
`ifdef FIFO_ARB_TAG_EN
    localparam int WR_W    = WIDTH + IDX_W
`else
    localparam int WR_W    = WIDTH
`endif
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst_L,
    input  logic [NUM_REQ-1:0]       i_Req_DV,
    input  logic [NUM_REQ*WIDTH-1:0] i_Req_Data,
    output logic [NUM_REQ-1:0]       o_Req_Ready,
    output logic                     o_Wr_DV,
    output logic [WR_W-1:0]          o_Wr_Data,
    input  logic                     i_Full,
    input  logic                     i_AF_Flag,
    output logic [IDX_W-1:0]         o_Grant_Idx,
    output logic                     o_Busy
);

    logic [NUM_REQ-1:0] hold_vld;
    logic [WIDTH-1:0]   hold_data [NUM_REQ];
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   ptr_nxt;
    logic               can_wr;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] grant_oh;
    logic [IDX_W-1:0]   grant_idx;
    logic               any_grant;
    logic [WR_W-1:0]    wr_word;

    // AF blocks a second write while the first is still invisible to the flags.
    assign can_wr  = !i_Full && !(i_AF_Flag && o_Wr_DV);
    assign arb_req = hold_vld & {NUM_REQ{can_wr}};

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ)
    ) u_rr (
        .req       (arb_req),
        .ptr       (ptr),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    always_comb begin
        wr_word = '0;
`ifdef FIFO_ARB_TAG_EN
        wr_word = {grant_idx, hold_data[grant_idx]};
`else
        wr_word = hold_data[grant_idx];
`endif
        if (grant_idx == IDX_W'(NUM_REQ - 1)) begin
            ptr_nxt = '0;
        end else begin
            ptr_nxt = grant_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            hold_vld <= '0;
            for (int n = 0; n < NUM_REQ; n++) begin
                hold_data[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_REQ; n++) begin
                if (grant_oh[n]) begin
                    hold_vld[n] <= 1'b0;
                end else if (i_Req_DV[n] && !hold_vld[n]) begin
                    hold_vld[n]  <= 1'b1;
                    hold_data[n] <= i_Req_Data[n*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Wr_DV     <= 1'b0;
            o_Wr_Data   <= '0;
            o_Grant_Idx <= '0;
            ptr         <= '0;
        end else begin
            o_Wr_DV <= any_grant;
            if (any_grant) begin
                o_Wr_Data   <= wr_word;
                o_Grant_Idx <= grant_idx;
                ptr         <= ptr_nxt;
            end
        end
    end

    assign o_Req_Ready = ~hold_vld;
    assign o_Busy      = |hold_vld;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a depth-4 FIFO flag model.
// Optional build macro: FIFO_ARB_TAG_EN also checks the index tag bits.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;
    localparam int IDX_W   = 2;
    localparam int DEPTH   = 4;
`ifdef FIFO_ARB_TAG_EN
    localparam int WR_W    = WIDTH + IDX_W;
`else
    localparam int WR_W    = WIDTH;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_REQ-1:0]       req_dv = '0;
    logic [NUM_REQ*WIDTH-1:0] req_data = '0;
    logic [NUM_REQ-1:0]       ready;
    logic                     wr_dv;
    logic [WR_W-1:0]          wr_data;
    logic                     full;
    logic                     af;
    logic [IDX_W-1:0]         gidx;
    logic                     busy;

    logic tbl_full = 1'b0;
    logic tbl_af = 1'b0;
    logic use_model = 1'b0;
    logic force_full = 1'b0;
    logic rd = 1'b0;
    logic hazard = 1'b0;
    int   cnt = 0;
    int   ovf = 0;
    int   b2b = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [7:0] wq [$];
    logic [7:0] pw [4][4];
    int         pc [4];
    int         pi [4];

    always #5 clk = ~clk;

    assign full = use_model ? (force_full || cnt == DEPTH) : tbl_full;
    assign af   = use_model ? (cnt >= DEPTH - 1) : tbl_af;

    fifo_wr_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .WIDTH       (WIDTH)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_n),
        .i_Req_DV    (req_dv),
        .i_Req_Data  (req_data),
        .o_Req_Ready (ready),
        .o_Wr_DV     (wr_dv),
        .o_Wr_Data   (wr_data),
        .i_Full      (full),
        .i_AF_Flag   (af),
        .o_Grant_Idx (gidx),
        .o_Busy      (busy)
    );

    // FIFO side: occupancy, written words, overflow and AF back-to-back watch
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 0;
            hazard <= 1'b0;
        end else begin
            if (wr_dv) begin
                wq.push_back(wr_data[WIDTH-1:0]);
                if (use_model && cnt == DEPTH) ovf <= ovf + 1;
            end
            if (hazard && wr_dv) b2b <= b2b + 1;
            hazard <= af && wr_dv;
            cnt <= cnt + ((wr_dv && cnt < DEPTH) ? 1 : 0)
                       - ((rd && cnt > 0) ? 1 : 0);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        logic [3:0] rs;
        @(negedge clk);
        for (int n = 0; n < NUM_REQ; n++) begin
            req_dv[n] = (pi[n] < pc[n]);
            if (pi[n] < pc[n]) req_data[n*WIDTH +: WIDTH] = pw[n][pi[n]];
        end
        rs = ready;
        @(posedge clk);
        for (int n = 0; n < NUM_REQ; n++) begin
            if (req_dv[n] && rs[n]) pi[n]++;
        end
        #1;
    endtask

    task automatic clr_prod();
        for (int n = 0; n < NUM_REQ; n++) begin
            pc[n] = 0;
            pi[n] = 0;
        end
        req_dv = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rd    = 1'b0;
        clr_prod();
        @(negedge clk);
        rst_n = 1'b1;
        wq.delete();
    endtask

    typedef struct {
        logic [3:0]  dv;
        logic [31:0] data;
        logic        full;
        logic        af;
        logic [3:0]  rdy;
        logic        wdv;
        logic [7:0]  wd;
        logic [1:0]  idx;
        logic        busy;
    } vec_t;

    localparam int NV = 21;
    vec_t tv [NV];

    initial begin
        tv[0]  = '{4'b1111, 32'h13121110, 0, 0, 4'b0000, 0, 8'h00, 2'd0, 1};
        tv[1]  = '{4'b0000, 32'h0,        0, 0, 4'b0001, 1, 8'h10, 2'd0, 1};
        tv[2]  = '{4'b0000, 32'h0,        0, 0, 4'b0011, 1, 8'h11, 2'd1, 1};
        tv[3]  = '{4'b0000, 32'h0,        0, 0, 4'b0111, 1, 8'h12, 2'd2, 1};
        tv[4]  = '{4'b0000, 32'h0,        0, 0, 4'b1111, 1, 8'h13, 2'd3, 0};
        tv[5]  = '{4'b0000, 32'h0,        0, 0, 4'b1111, 0, 8'h00, 2'd0, 0};
        tv[6]  = '{4'b0100, 32'h00AB0000, 0, 0, 4'b1011, 0, 8'h00, 2'd0, 1};
        tv[7]  = '{4'b0000, 32'h0,        0, 0, 4'b1111, 1, 8'hAB, 2'd2, 0};
        tv[8]  = '{4'b0010, 32'h00002100, 0, 0, 4'b1101, 0, 8'h00, 2'd0, 1};
        tv[9]  = '{4'b0010, 32'h00002200, 0, 0, 4'b1111, 1, 8'h21, 2'd1, 0};
        tv[10] = '{4'b0010, 32'h00002200, 0, 0, 4'b1101, 0, 8'h00, 2'd0, 1};
        tv[11] = '{4'b0000, 32'h0,        0, 0, 4'b1111, 1, 8'h22, 2'd1, 0};
        tv[12] = '{4'b1001, 32'h33000030, 0, 1, 4'b0110, 0, 8'h00, 2'd0, 1};
        tv[13] = '{4'b0000, 32'h0,        0, 1, 4'b1110, 1, 8'h33, 2'd3, 1};
        tv[14] = '{4'b0000, 32'h0,        0, 1, 4'b1110, 0, 8'h00, 2'd0, 1};
        tv[15] = '{4'b0000, 32'h0,        0, 1, 4'b1111, 1, 8'h30, 2'd0, 0};
        tv[16] = '{4'b0100, 32'h00440000, 1, 0, 4'b1011, 0, 8'h00, 2'd0, 1};
        tv[17] = '{4'b0000, 32'h0,        1, 0, 4'b1011, 0, 8'h00, 2'd0, 1};
        tv[18] = '{4'b0000, 32'h0,        0, 0, 4'b1111, 1, 8'h44, 2'd2, 0};
        tv[19] = '{4'b1000, 32'h5A000000, 0, 0, 4'b0111, 0, 8'h00, 2'd0, 1};
        tv[20] = '{4'b0000, 32'h0,        0, 0, 4'b1111, 1, 8'h5A, 2'd3, 0};

        clr_prod();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'hF);
        chk("rst_wr_dv", 32'(wr_dv), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_idx",   32'(gidx), 32'h0);
        chk("rst_data",  32'(wr_data), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            req_dv   = tv[i].dv;
            req_data = tv[i].data;
            tbl_full = tv[i].full;
            tbl_af   = tv[i].af;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ready", i), 32'(ready), 32'(tv[i].rdy));
            chk($sformatf("v%0d_wr_dv", i), 32'(wr_dv), 32'(tv[i].wdv));
            chk($sformatf("v%0d_busy", i),  32'(busy), 32'(tv[i].busy));
            if (tv[i].wdv) begin
                chk($sformatf("v%0d_data", i), 32'(wr_data[WIDTH-1:0]),
                    32'(tv[i].wd));
                chk($sformatf("v%0d_idx", i), 32'(gidx), 32'(tv[i].idx));
`ifdef FIFO_ARB_TAG_EN
                chk($sformatf("v%0d_tag", i), 32'(wr_data), 
                    32'({tv[i].idx, tv[i].wd}));
`endif
            end
        end
        @(negedge clk);
        req_dv = '0;

        // reset while words are held discards them
        do_reset();
        use_model  = 1'b1;
        force_full = 1'b1;
        for (int n = 0; n < NUM_REQ; n++) begin
            pw[n][0] = 8'h70 + 8'(n);
            pc[n]    = 1;
        end
        step();
        chk("mid_busy", 32'(busy), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        clr_prod();
        #1;
        chk("mid_rst_ready", 32'(ready), 32'hF);
        chk("mid_rst_busy",  32'(busy), 32'h0);
        chk("mid_rst_wr_dv", 32'(wr_dv), 32'h0);
        @(negedge clk);
        rst_n      = 1'b1;
        force_full = 1'b0;
        wq.delete();
        repeat (3) step();
        chk("mid_no_write", 32'(wq.size()), 32'h0);

        // backpressure: Full holds all words
        do_reset();
        force_full = 1'b1;
        for (int n = 0; n < NUM_REQ; n++) begin
            pw[n][0] = 8'h60 + 8'(n);
            pc[n]    = 1;
        end
        repeat (6) step();
        chk("bp_ready", 32'(ready), 32'h0);
        chk("bp_no_wr", 32'(wq.size()), 32'h0);
        force_full = 1'b0;
        repeat (8) step();
        chk("bp_count", 32'(wq.size()), 32'h4);
        for (int k = 0; k < 4; k++) begin
            if (k < wq.size())
                chk($sformatf("bp_word%0d", k), 32'(wq[k]), 32'h60 + 32'(k));
        end
        chk("bp_fifo_cnt", 32'(cnt), 32'h4);

        // fill: six words into a depth-4 FIFO with no reads
        do_reset();
        pw[0][0] = 8'h50; pw[0][1] = 8'h54; pc[0] = 2;
        pw[1][0] = 8'h51; pw[1][1] = 8'h55; pc[1] = 2;
        pw[2][0] = 8'h52; pc[2] = 1;
        pw[3][0] = 8'h53; pc[3] = 1;
        repeat (12) step();
        chk("fill_count", 32'(wq.size()), 32'h4);
        for (int k = 0; k < 4; k++) begin
            if (k < wq.size())
                chk($sformatf("fill_word%0d", k), 32'(wq[k]), 32'h50 + 32'(k));
        end
        chk("fill_full",  32'(full), 32'h1);
        chk("fill_busy",  32'(busy), 32'h1);
        chk("fill_ready", 32'(ready), 32'hC);
        rd = 1'b1;
        step();
        rd = 1'b0;
        repeat (6) step();
        chk("read_count", 32'(wq.size()), 32'h5);
        if (wq.size() > 4) chk("read_word", 32'(wq[4]), 32'h54);
        chk("read_ready", 32'(ready), 32'hD);
        chk("read_fifo_cnt", 32'(cnt), 32'h4);

        chk("overflow_writes", 32'(ovf), 32'h0);
        chk("af_back_to_back", 32'(b2b), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
